// File: rtl/core_debug_ctrl.sv
// Run/halt/step debug controller: gates PC update and arbitrates the register
// file write port and read port 1 between the core and the host debug port.
module core_debug_ctrl #(
    parameter bit HALT_ON_RESET = 1'b0,
    parameter int XLEN          = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            host_cmd_valid,
    output logic            host_cmd_ready,
    input  logic [1:0]      host_cmd_op,
    input  logic            host_cmd_we,
    input  logic [4:0]      host_cmd_addr,
    input  logic [XLEN-1:0] host_cmd_wdata,
    output logic            host_rsp_valid,
    input  logic            host_rsp_ready,
    output logic [XLEN-1:0] host_rsp_data,
    output logic            host_rsp_err,
    input  logic [XLEN-1:0] pc_value,
    output logic            pc_en,
    input  logic            core_reg_write,
    input  logic [4:0]      core_rd,
    input  logic [XLEN-1:0] core_wdata,
    input  logic [4:0]      core_rs1,
    output logic            rf_reg_write,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write_data,
    output logic [4:0]      rf_rs1,
    input  logic [XLEN-1:0] rf_read_data1,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_RUN, S_HALTED, S_STEP, S_ACCESS, S_RESP
    } state_t;

    localparam logic [1:0] OP_HALT   = 2'b00;
    localparam logic [1:0] OP_RESUME = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;

    state_t            state_q;
    state_t            ret_q;
    logic              we_q;
    logic [4:0]        addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              rsp_err_q;
    logic              rsp_pc_q;
    logic              host_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HALT_ON_RESET ? S_HALTED : S_RUN;
            ret_q      <= HALT_ON_RESET ? S_HALTED : S_RUN;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_pc_q   <= 1'b0;
        end else begin
            case (state_q)
                S_RUN, S_HALTED: begin
                    if (host_cmd_valid) begin
                        we_q       <= host_cmd_we;
                        addr_q     <= host_cmd_addr;
                        wdata_q    <= host_cmd_wdata;
                        rsp_data_q <= pc_value;
                        rsp_err_q  <= 1'b0;
                        rsp_pc_q   <= 1'b0;
                        ret_q      <= state_q;
                        state_q    <= S_RESP;
                        case (host_cmd_op)
                            OP_HALT:   ret_q <= S_HALTED;
                            OP_RESUME: ret_q <= S_RUN;
                            default: begin
                                if (state_q == S_RUN) begin
                                    rsp_err_q  <= 1'b1;
                                    rsp_data_q <= '0;
                                end else if (host_cmd_op == OP_STEP) begin
                                    state_q <= S_STEP;
                                end else begin
                                    state_q <= S_ACCESS;
                                end
                            end
                        endcase
                    end
                end
                S_STEP: begin
                    // New PC only appears after this edge; RESP forwards the frozen pc_value.
                    rsp_pc_q <= 1'b1;
                    rsp_err_q <= 1'b0;
                    ret_q    <= S_HALTED;
                    state_q  <= S_RESP;
                end
                S_ACCESS: begin
                    rsp_data_q <= (we_q || addr_q == 5'd0) ? '0 : rf_read_data1;
                    rsp_err_q  <= 1'b0;
                    ret_q      <= S_HALTED;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    if (host_rsp_ready) begin
                        rsp_pc_q <= 1'b0;
                        state_q  <= ret_q;
                    end
                end
                default: state_q <= S_HALTED;
            endcase
        end
    end

    assign host_cmd_ready = (state_q == S_RUN) || (state_q == S_HALTED);
    assign pc_en          = (state_q == S_RUN) || (state_q == S_STEP);
    assign halted         = (state_q != S_RUN);
    assign host_rsp_valid = (state_q == S_RESP);
    assign host_rsp_err   = rsp_err_q;
    assign host_rsp_data  = rsp_pc_q ? pc_value : rsp_data_q;

    // Reset must be able to cancel a host write still pending in ACCESS.
    assign host_wr        = (state_q == S_ACCESS) && we_q && !reset;

    assign rf_reg_write   = pc_en ? core_reg_write : host_wr;
    assign rf_rd          = pc_en ? core_rd        : addr_q;
    assign rf_write_data  = pc_en ? core_wdata     : wdata_q;
    assign rf_rs1         = (state_q == S_ACCESS) ? addr_q : core_rs1;

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Directed bench for core_debug_ctrl with a small PC and register-file environment.
module tb_core_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_cmd_valid = 1'b0;
    logic [1:0]  host_cmd_op = 2'b00;
    logic        host_cmd_we = 1'b0;
    logic [4:0]  host_cmd_addr = 5'd0;
    logic [31:0] host_cmd_wdata = 32'd0;
    logic        host_rsp_ready = 1'b1;
    logic        core_reg_write = 1'b0;
    logic [4:0]  core_rd = 5'd0;
    logic [31:0] core_wdata = 32'd0;
    logic [4:0]  core_rs1 = 5'd0;
    logic [31:0] pc_value = 32'd0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = 32'd0;

    logic        host_cmd_ready, host_rsp_valid, host_rsp_err, pc_en, halted;
    logic [31:0] host_rsp_data, rf_write_data, rf_read_data1;
    logic        rf_reg_write;
    logic [4:0]  rf_rd, rf_rs1;

    logic        h_cmd_ready, h_rsp_valid, h_rsp_err, h_pc_en, h_halted, h_rf_reg_write;
    logic [31:0] h_rsp_data, h_rf_write_data;
    logic [4:0]  h_rf_rd, h_rf_rs1;

    logic [31:0] regs [32];
    int          pc_en_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    core_debug_ctrl #(.HALT_ON_RESET(1'b0), .XLEN(32)) u_dut (
        .clk(clk), .reset(reset),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_cmd_we(host_cmd_we),
        .host_cmd_addr(host_cmd_addr), .host_cmd_wdata(host_cmd_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
        .pc_value(pc_value), .pc_en(pc_en),
        .core_reg_write(core_reg_write), .core_rd(core_rd),
        .core_wdata(core_wdata), .core_rs1(core_rs1),
        .rf_reg_write(rf_reg_write), .rf_rd(rf_rd),
        .rf_write_data(rf_write_data), .rf_rs1(rf_rs1),
        .rf_read_data1(rf_read_data1), .halted(halted)
    );

    core_debug_ctrl #(.HALT_ON_RESET(1'b1), .XLEN(32)) u_dut_h (
        .clk(clk), .reset(reset),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(h_cmd_ready),
        .host_cmd_op(host_cmd_op), .host_cmd_we(host_cmd_we),
        .host_cmd_addr(host_cmd_addr), .host_cmd_wdata(host_cmd_wdata),
        .host_rsp_valid(h_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_data(h_rsp_data), .host_rsp_err(h_rsp_err),
        .pc_value(pc_value), .pc_en(h_pc_en),
        .core_reg_write(core_reg_write), .core_rd(core_rd),
        .core_wdata(core_wdata), .core_rs1(core_rs1),
        .rf_reg_write(h_rf_reg_write), .rf_rd(h_rf_rd),
        .rf_write_data(h_rf_write_data), .rf_rs1(h_rf_rs1),
        .rf_read_data1(rf_read_data1), .halted(h_halted)
    );

    // Environment: PC register gated by pc_en, register file with hardwired x0.
    always @(posedge clk) begin
        if (pc_load) pc_value <= pc_load_val;
        else if (pc_en) pc_value <= pc_value + 32'd4;
    end
    always @(posedge clk) if (rf_reg_write && rf_rd != 5'd0) regs[rf_rd] <= rf_write_data;
    always @(posedge clk) if (pc_en) pc_en_cnt <= pc_en_cnt + 1;
    assign rf_read_data1 = (rf_rs1 == 5'd0) ? 32'd0 : regs[rf_rs1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_pc(input logic [31:0] v);
        @(negedge clk); pc_load = 1'b1; pc_load_val = v;
        @(negedge clk); pc_load = 1'b0;
    endtask

    // Called at a negedge with the controller ready; returns at the first
    // negedge where the response is valid.
    task automatic do_cmd(input logic [1:0] op, input logic we, input logic [4:0] addr,
                          input logic [31:0] wd, output logic [31:0] data,
                          output logic err, output int lat);
        chk("cmd_ready_before_cmd", {31'd0, host_cmd_ready}, 32'd1);
        host_cmd_valid = 1'b1; host_cmd_op = op; host_cmd_we = we;
        host_cmd_addr = addr; host_cmd_wdata = wd;
        @(negedge clk);
        host_cmd_valid = 1'b0;
        lat = 1;
        while (!host_rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        data = host_rsp_data;
        err  = host_rsp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          cnt0;
        logic [31:0] exp_pc;

        repeat (3) @(negedge clk);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_rsp_valid", {31'd0, host_rsp_valid}, 32'd0);
        chk("rst_rsp_data", host_rsp_data, 32'd0);
        chk("rst_cmd_ready", {31'd0, host_cmd_ready}, 32'd1);
        chk("rst_h_halted", {31'd0, h_halted}, 32'd1);
        chk("rst_h_pc_en", {31'd0, h_pc_en}, 32'd0);
        reset = 1'b0;

        // HALT while running at PC 0x10
        load_pc(32'h10);
        do_cmd(2'b00, 1'b0, 5'd0, 32'd0, d, e, lat);
        chk("halt_lat", lat, 32'd1);
        chk("halt_data", d, 32'h10);
        chk("halt_err", {31'd0, e}, 32'd0);
        chk("halt_pc_en_next", {31'd0, pc_en}, 32'd0);
        core_reg_write = 1'b1; core_rd = 5'd5; core_wdata = 32'hBAD0BAD0;
        #1;
        chk("halt_core_wr_blocked", {31'd0, rf_reg_write}, 32'd0);
        @(negedge clk);
        chk("halted_state", {31'd0, halted}, 32'd1);
        chk("halted_pc_en", {31'd0, pc_en}, 32'd0);
        chk("halted_core_wr_blocked", {31'd0, rf_reg_write}, 32'd0);

        // Register access while halted
        do_cmd(2'b11, 1'b1, 5'd5, 32'hDEADBEEF, d, e, lat);
        chk("wr_x5_lat", lat, 32'd2);
        chk("wr_x5_data", d, 32'd0);
        chk("wr_x5_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        do_cmd(2'b11, 1'b0, 5'd5, 32'd0, d, e, lat);
        chk("rd_x5_data", d, 32'hDEADBEEF);
        chk("rd_x5_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        do_cmd(2'b11, 1'b1, 5'd0, 32'h1234, d, e, lat);
        chk("wr_x0_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        do_cmd(2'b11, 1'b0, 5'd0, 32'd0, d, e, lat);
        chk("rd_x0_data", d, 32'd0);
        chk("rd_x0_err", {31'd0, e}, 32'd0);
        @(negedge clk);

        // Single step from PC 0x20; the core writeback of x5 is forwarded
        load_pc(32'h20);
        cnt0 = pc_en_cnt;
        do_cmd(2'b10, 1'b0, 5'd0, 32'd0, d, e, lat);
        chk("step_lat", lat, 32'd2);
        chk("step_data", d, 32'h24);
        chk("step_err", {31'd0, e}, 32'd0);
        chk("step_pc_en_cycles", pc_en_cnt - cnt0, 32'd1);
        @(negedge clk);
        chk("step_back_halted", {31'd0, halted}, 32'd1);
        chk("step_pc_en_cycles_after", pc_en_cnt - cnt0, 32'd1);
        do_cmd(2'b11, 1'b0, 5'd5, 32'd0, d, e, lat);
        chk("step_core_wb_x5", d, 32'hBAD0BAD0);
        core_reg_write = 1'b0;
        @(negedge clk);

        // RESUME, then illegal STEP and REG while running
        do_cmd(2'b01, 1'b0, 5'd0, 32'd0, d, e, lat);
        chk("resume_lat", lat, 32'd1);
        chk("resume_err", {31'd0, e}, 32'd0);
        chk("resume_data", d, 32'h24);
        @(negedge clk);
        chk("resume_running", {31'd0, halted}, 32'd0);
        chk("resume_pc_en", {31'd0, pc_en}, 32'd1);
        do_cmd(2'b10, 1'b0, 5'd0, 32'd0, d, e, lat);
        chk("run_step_lat", lat, 32'd1);
        chk("run_step_err", {31'd0, e}, 32'd1);
        chk("run_step_data", d, 32'd0);
        @(negedge clk);
        chk("run_step_pc_en", {31'd0, pc_en}, 32'd1);
        do_cmd(2'b11, 1'b1, 5'd7, 32'h77, d, e, lat);
        chk("run_reg_err", {31'd0, e}, 32'd1);
        chk("run_reg_data", d, 32'd0);
        @(negedge clk);
        chk("run_reg_pc_en", {31'd0, pc_en}, 32'd1);
        chk("run_reg_halted", {31'd0, halted}, 32'd0);

        // HALT with response backpressure
        host_rsp_ready = 1'b0;
        exp_pc = pc_value;
        host_cmd_valid = 1'b1; host_cmd_op = 2'b00;
        @(negedge clk);
        host_cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, host_rsp_valid}, 32'd1);
            chk("bp_data", host_rsp_data, exp_pc);
            chk("bp_err", {31'd0, host_rsp_err}, 32'd0);
            chk("bp_cmd_ready", {31'd0, host_cmd_ready}, 32'd0);
            @(negedge clk);
        end
        chk("bp_valid_c6", {31'd0, host_rsp_valid}, 32'd1);
        host_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_after", {31'd0, host_rsp_valid}, 32'd0);
        chk("bp_cmd_ready_after", {31'd0, host_cmd_ready}, 32'd1);
        chk("bp_halted_after", {31'd0, halted}, 32'd1);

        // Reset during a pending ACCESS write
        do_cmd(2'b11, 1'b1, 5'd9, 32'h11, d, e, lat);
        @(negedge clk);
        host_cmd_valid = 1'b1; host_cmd_op = 2'b11; host_cmd_we = 1'b1;
        host_cmd_addr = 5'd9; host_cmd_wdata = 32'h99;
        @(negedge clk);
        host_cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_access_no_write", {31'd0, rf_reg_write}, 32'd0);
        @(negedge clk);
        chk("rst_access_rsp_valid", {31'd0, host_rsp_valid}, 32'd0);
        chk("rst_access_state_run", {31'd0, halted}, 32'd0);
        chk("rst_access_h_halted", {31'd0, h_halted}, 32'd1);
        reset = 1'b0;
        do_cmd(2'b00, 1'b0, 5'd0, 32'd0, d, e, lat);
        chk("rst_access_halt_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        do_cmd(2'b11, 1'b0, 5'd9, 32'd0, d, e, lat);
        chk("rst_access_x9_kept", d, 32'h11);
        @(negedge clk);

        // Reset while a response is stalled
        host_rsp_ready = 1'b0;
        do_cmd(2'b01, 1'b0, 5'd0, 32'd0, d, e, lat);
        chk("rst_resp_pending", {31'd0, host_rsp_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, host_rsp_valid}, 32'd0);
        chk("rst_resp_data", host_rsp_data, 32'd0);
        chk("rst_resp_err", {31'd0, host_rsp_err}, 32'd0);
        chk("rst_resp_state_run", {31'd0, halted}, 32'd0);
        chk("rst_resp_h_halted", {31'd0, h_halted}, 32'd1);
        chk("rst_resp_h_valid", {31'd0, h_rsp_valid}, 32'd0);
        reset = 1'b0;
        host_rsp_ready = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
